// File: rtl/cv32e40p_fpga_obi_mem.sv
// Shared block-RAM behind the cv32e40p instruction and data OBI ports, with configurable
// grant wait states and response latency, plus the post-reset fetch-enable sequencer.
module cv32e40p_fpga_obi_mem #(
    parameter int          MEM_WORDS    = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          GNT_WAIT     = 0,
    parameter int          READ_LATENCY = 1,
    parameter int          BOOT_DELAY   = 16,
    parameter string       INIT_FILE    = ""
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,

    output logic        oor_err_o,
    output logic        fetch_enable_o
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0]   instr_off;
    logic [31:0]   data_off;
    logic          instr_in_range;
    logic          data_in_range;
    logic [AW-1:0] instr_idx;
    logic [AW-1:0] data_idx;
    logic [1:0]    instr_wait;
    logic [1:0]    data_wait;
    logic          instr_accept;
    logic          data_accept;

    // Range test uses the full byte offset so addresses below BASE_ADDR wrap to out-of-range.
    assign instr_off      = instr_addr_i - BASE_ADDR;
    assign data_off       = data_addr_i - BASE_ADDR;
    assign instr_in_range = {1'b0, instr_off} < MEM_BYTES;
    assign data_in_range  = {1'b0, data_off} < MEM_BYTES;
    assign instr_idx      = instr_off[AW+1:2];
    assign data_idx       = data_off[AW+1:2];

    assign instr_gnt_o  = rst_ni && instr_req_i && (instr_wait == 2'(GNT_WAIT));
    assign data_gnt_o   = rst_ni && data_req_i && (data_wait == 2'(GNT_WAIT));
    assign instr_accept = instr_req_i && instr_gnt_o;
    assign data_accept  = data_req_i && data_gnt_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !instr_req_i || instr_gnt_o) begin
            instr_wait <= '0;
        end else begin
            instr_wait <= instr_wait + 2'd1;
        end
        if (!rst_ni || !data_req_i || data_gnt_o) begin
            data_wait <= '0;
        end else begin
            data_wait <= data_wait + 2'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (data_accept && data_we_i && data_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (data_be_i[b]) begin
                    mem[data_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                end
            end
        end
    end

    logic        instr_vld [READ_LATENCY];
    logic        data_vld  [READ_LATENCY];
    logic [31:0] instr_dat [READ_LATENCY];
    logic [31:0] data_dat  [READ_LATENCY];

    // Stage 0 samples the array at the acceptance edge, so a same-cycle write is not yet visible.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                instr_vld[i] <= 1'b0;
                data_vld[i]  <= 1'b0;
                instr_dat[i] <= '0;
                data_dat[i]  <= '0;
            end
        end else begin
            instr_vld[0] <= instr_accept;
            data_vld[0]  <= data_accept;
            instr_dat[0] <= (instr_accept && instr_in_range) ? mem[instr_idx] : '0;
            data_dat[0]  <= (data_accept && !data_we_i && data_in_range) ? mem[data_idx] : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                instr_vld[i] <= instr_vld[i-1];
                data_vld[i]  <= data_vld[i-1];
                instr_dat[i] <= instr_dat[i-1];
                data_dat[i]  <= data_dat[i-1];
            end
        end
    end

    assign instr_rvalid_o = instr_vld[READ_LATENCY-1];
    assign instr_rdata_o  = instr_dat[READ_LATENCY-1];
    assign data_rvalid_o  = data_vld[READ_LATENCY-1];
    assign data_rdata_o   = data_dat[READ_LATENCY-1];

    logic oor_err;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            oor_err <= 1'b0;
        end else if ((instr_accept && !instr_in_range) || (data_accept && !data_in_range)) begin
            oor_err <= 1'b1;
        end
    end

    assign oor_err_o = oor_err;

    logic [7:0] boot_cnt;
    logic       fetch_en;

    // The counter freezes once fetch is enabled, so it never wraps.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            boot_cnt <= '0;
            fetch_en <= 1'b0;
        end else if (!fetch_en) begin
            boot_cnt <= boot_cnt + 8'd1;
            fetch_en <= (boot_cnt == 8'(BOOT_DELAY - 1));
        end
    end

    assign fetch_enable_o = fetch_en;

endmodule
